// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared playfield constants and bird state type
package flappy_pkg;

  localparam int ROWS  = 16;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, RISE, FALL, DEAD} bird_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running motion step divider with synchronous clear
module tick_gen #(
  parameter int DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign step = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bird_ctrl.sv
// rtl/bird_ctrl.sv - bird motion FSM: flap rise, apex hover, gravity fall, death
module bird_ctrl #(
  parameter int ROWS      = flappy_pkg::ROWS,
  parameter int START_ROW = 8,
  parameter int TICK_DIV  = 12_500_000,
  parameter int FLAP_RISE = 3,
  localparam int ROW_W    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flap,
  input  logic             hit,
  output logic [ROW_W-1:0] bird_row,
  output logic [ROWS-1:0]  bird_col,
  output logic             alive,
  output logic             crash
);

  import flappy_pkg::*;

  localparam int RC_W = (FLAP_RISE > 1) ? $clog2(FLAP_RISE) : 1;

  bird_state_t       state, state_n;
  logic [ROW_W-1:0]  row_n, row_inc;
  logic [RC_W-1:0]   rise_cnt, rc_n;
  logic              crash_n;
  logic              clr;
  logic              step;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .step  (step)
  );

  // Ceiling saturates silently; only the floor or a hit is fatal.
  assign row_inc  = (bird_row == ROW_W'(ROWS - 1)) ? bird_row : bird_row + ROW_W'(1);
  assign bird_col = ROWS'(1) << bird_row;
  assign alive    = (state != DEAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bird_row <= ROW_W'(START_ROW);
      rise_cnt <= '0;
      crash    <= 1'b0;
    end else begin
      state    <= state_n;
      bird_row <= row_n;
      rise_cnt <= rc_n;
      crash    <= crash_n;
    end
  end

  // Priority hit > flap > step; a flap restarts the step phase.
  always_comb begin
    state_n = state;
    row_n   = bird_row;
    rc_n    = rise_cnt;
    crash_n = crash;
    clr     = 1'b0;
    if (state != DEAD) begin
      if (hit) begin
        state_n = DEAD;
        crash_n = 1'b1;
      end else if (flap) begin
        state_n = RISE;
        row_n   = row_inc;
        rc_n    = RC_W'(FLAP_RISE - 1);
        clr     = 1'b1;
      end else if (step) begin
        case (state)
          RISE: begin
            if (rise_cnt != '0) begin
              row_n = row_inc;
              rc_n  = rise_cnt - RC_W'(1);
            end else begin
              state_n = FALL;
            end
          end
          FALL: begin
            if (bird_row != '0) begin
              row_n = bird_row - ROW_W'(1);
            end else begin
              state_n = DEAD;
              crash_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_ctrl.sv
// tb/tb_bird_ctrl.sv - self-checking bench for bird_ctrl with behavioural model
module tb_bird_ctrl;

  localparam int ROWS = 16;
  localparam int TICK = 4;
  localparam int RISE_N = 3;
  localparam int START = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flap = 1'b0;
  logic        hit = 1'b0;
  logic [3:0]  bird_row;
  logic [15:0] bird_col;
  logic        alive;
  logic        crash;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  bird_ctrl #(
    .ROWS      (ROWS),
    .START_ROW (START),
    .TICK_DIV  (TICK),
    .FLAP_RISE (RISE_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flap     (flap),
    .hit      (hit),
    .bird_row (bird_row),
    .bird_col (bird_col),
    .alive    (alive),
    .crash    (crash)
  );

  always #5 clk = ~clk;

  // Model: mode 0 waiting, 1 climbing, 2 falling, 3 dead.
  int m_row, m_rem, m_elapsed, m_mode;
  bit m_crash;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_row = START; m_rem = 0; m_elapsed = 0; m_mode = 0; m_crash = 0;
    end else if (m_mode != 3) begin
      if (hit) begin
        m_mode = 3; m_crash = 1;
      end else if (flap) begin
        m_mode = 1; m_row = (m_row + 1 > ROWS - 1) ? ROWS - 1 : m_row + 1;
        m_rem = RISE_N - 1; m_elapsed = 0;
      end else begin
        bit stepping;
        stepping = (m_elapsed % TICK) == TICK - 1;
        m_elapsed = m_elapsed + 1;
        if (stepping && m_mode == 1) begin
          if (m_rem > 0) begin
            m_row = (m_row + 1 > ROWS - 1) ? ROWS - 1 : m_row + 1;
            m_rem = m_rem - 1;
          end else m_mode = 2;
        end else if (stepping && m_mode == 2) begin
          if (m_row > 0) m_row = m_row - 1;
          else begin m_mode = 3; m_crash = 1; end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row_vs_model", int'(bird_row), m_row);
      chk("col_vs_model", int'(bird_col), 1 << m_row);
      chk("alive_vs_model", int'(alive), (m_mode != 3) ? 1 : 0);
      chk("crash_vs_model", int'(crash), int'(m_crash));
    end
  end

  task automatic tick(input logic f, input logic h);
    @(negedge clk);
    #1;
    flap = f;
    hit = h;
  endtask

  task automatic do_reset();
    tick(0, 0);
    reset = 1'b0;
    repeat (2) tick(0, 0);
    reset = 1'b1;
  endtask

  task automatic pin_row(input string name, input int exp);
    chk({name, "_dut"}, int'(bird_row), exp);
    chk({name, "_model"}, m_row, exp);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #1 reset = 1'b1;

    // Reset hold: 100 idle cycles, no movement
    repeat (100) tick(0, 0);
    pin_row("idle_row", 8);
    chk("idle_col", int'(bird_col), 16'h0100);
    chk("idle_alive", int'(alive), 1);
    chk("idle_crash", int'(crash), 0);

    // Single flap: +1, +1 at 4, +1 at 8, hover at 12, fall at 16
    tick(1, 0);
    tick(0, 0);
    pin_row("flap_e0", 9);
    repeat (4) tick(0, 0);
    pin_row("flap_e4", 10);
    repeat (4) tick(0, 0);
    pin_row("flap_e8", 11);
    repeat (4) tick(0, 0);
    pin_row("flap_e12_hover", 11);
    repeat (4) tick(0, 0);
    pin_row("flap_e16_fall", 10);

    // Floor crash
    waited = 0;
    while (alive === 1'b1 && waited < 200) begin
      tick(0, 0);
      waited++;
    end
    chk("floor_death_in_time", (waited < 200) ? 1 : 0, 1);
    pin_row("floor_row", 0);
    chk("floor_crash", int'(crash), 1);
    repeat (3) begin tick(1, 0); tick(0, 0); end
    tick(0, 1);
    tick(0, 0);
    pin_row("dead_flap_row", 0);
    chk("dead_alive", int'(alive), 0);

    // Ceiling saturation
    do_reset();
    repeat (20) begin tick(1, 0); tick(0, 0); end
    pin_row("ceiling_row", 15);
    chk("ceiling_alive", int'(alive), 1);
    chk("ceiling_col", int'(bird_col), 16'h8000);

    // Hit beats flap at row 10
    do_reset();
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    pin_row("pre_hit_row", 10);
    tick(1, 1);
    tick(0, 0);
    pin_row("hit_row", 10);
    chk("hit_crash", int'(crash), 1);
    chk("hit_alive", int'(alive), 0);

    // Asynchronous reset between edges during RISE
    do_reset();
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    pin_row("mid_rise_row", 9);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_row", int'(bird_row), 8);
    chk("async_col", int'(bird_col), 16'h0100);
    chk("async_alive", int'(alive), 1);
    chk("async_crash", int'(crash), 0);
    repeat (2) tick(0, 0);
    reset = 1'b1;

    // Randomized play checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        tick(0, 0);
        reset = 1'b1;
      end
    end

    tick(0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bird_ctrl.md
BIRD_CTRL -- requirements
Module: bird_ctrl

Interface
REQ-001 Parameter ROWS, default 16: playfield height in rows; row 0 is the floor and ROWS-1 is the ceiling.
REQ-002 Parameter START_ROW, default 8: bird row after reset.
REQ-003 Parameter TICK_DIV, default 12_500_000: clock cycles per motion step.
REQ-004 Parameter FLAP_RISE, default 3: number of rows gained per flap.
REQ-005 clk  input  1: single system clock; all state updates on the rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 flap  input  1: one-cycle flap pulse from the key-conditioning block, synchronous to clk.
REQ-008 hit  input  1: collision flag from pipe logic, level-sensitive, synchronous to clk.
REQ-009 bird_row  output  ROW_W: current bird row, where ROW_W = $clog2(ROWS).
REQ-010 bird_col  output  ROWS: one-hot LED column, with bird_col[bird_row]=1.
REQ-011 alive  output  1: high in every state except DEAD.
REQ-012 crash  output  1: sticky, set on entry to DEAD.

Function
REQ-013 The block SHALL implement four states: IDLE, RISE, FALL, DEAD.
REQ-014 A step strobe SHALL fire for one cycle when the tick counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-015 In IDLE, the bird SHALL not move; step strobes SHALL be ignored; flap SHALL cause a transition to RISE.
REQ-016 On flap in IDLE, RISE or FALL, the next edge SHALL produce all of the following:
- state=RISE
- bird_row+1, saturating at ROWS-1
- rise_cnt=FLAP_RISE-1
- tick counter=0
REQ-017 In RISE on a step: if rise_cnt>0, bird_row SHALL increment (saturating) and rise_cnt SHALL decrement; if rise_cnt==0, the state SHALL go to FALL with the row unchanged (apex hover).
REQ-018 In FALL on a step: if bird_row>0, bird_row SHALL decrement; if bird_row==0, the state SHALL go to DEAD.
REQ-019 When hit=1 in IDLE, RISE or FALL, the next edge SHALL enter DEAD; bird_row SHALL be frozen.
REQ-020 Event priority on the same cycle SHALL be hit > flap > step; a flap SHALL suppress that cycle's step.
REQ-021 In DEAD, flap, hit and step SHALL be ignored; only reset exits DEAD.
REQ-022 crash SHALL be set on the edge that enters DEAD and SHALL hold until reset.
REQ-023 bird_col SHALL be a combinational decode of registered bird_row; the row-to-LED latency SHALL be 0 cycles.
REQ-024 Ceiling saturation SHALL not cause death; only the floor step or hit causes death.

Reset
REQ-025 While reset=0, the block SHALL immediately hold, without waiting for a clock edge:
- state=IDLE
- bird_row=START_ROW
- rise_cnt=0
- tick counter=0
- crash=0
- alive=1
REQ-026 Reset SHALL be honoured in any state, including mid-RISE and DEAD.
REQ-027 The first flap after reset deassertion SHALL be acted upon normally.

Structure
REQ-028 Package flappy_pkg SHALL hold the following; this block SHALL import it:
- ROWS
- ROW_W
- the bird_state_t enum {IDLE, RISE, FALL, DEAD}
REQ-029 The tick divider SHALL be a sub-module tick_gen with the following properties:
- parameter DIV
- inputs clk, reset and clr
- output step
- clr forces the count to 0
REQ-030 The FSM and row arithmetic SHALL live in bird_ctrl.

Verification
All scenarios use TICK_DIV=4, FLAP_RISE=3, START_ROW=8, ROWS=16.
REQ-031 Reset scenario:
- Stimulus: apply reset, then idle 100 cycles.
- Response: bird_row=8, bird_col=16'h0100, alive=1, crash=0, with no change.
REQ-032 Single flap from IDLE:
- Stimulus: one flap pulse.
- Response: next edge row=9; +4 cycles row=10; +8 cycles row=11; +12 cycles hover at 11 and FALL; then row decrements every 4 cycles.
REQ-033 Floor crash:
- Stimulus: no further flaps after the single-flap scenario.
- Response: row reaches 0; the next step gives DEAD, crash=1, alive=0; later flaps leave row=0.
REQ-034 Ceiling:
- Stimulus: flap every 2 cycles for 40 cycles.
- Response: row saturates at 15 and alive stays 1.
REQ-035 Collision priority:
- Stimulus: hit and flap in the same cycle at row 10.
- Response: DEAD, row stays 10, crash=1.
REQ-036 Asynchronous reset mid-operation:
- Stimulus: drive reset low between clock edges during RISE.
- Response: outputs return to their reset values before the next edge.
